// File: rtl/spi_move_receiver.sv
// SPI mode-0 slave that receives move-command bytes, queues them in a small FIFO for the
// game logic, and returns a status byte on MISO with each byte so the MCU can pace itself.
`timescale 1ns/1ps
module spi_move_receiver #(
   parameter int         FIFO_DEPTH  = 4,
   parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sck,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic [2:0] move,
   output logic       move_valid,
   input  logic       move_ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int         AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [7:0] CLEAR_BYTE = {SYNC_NIBBLE, 4'h7};

   // NOP and the reserved code are decoded but never queued
   function automatic logic code_pushable(input logic [2:0] code);
      return (code != 3'd0) && (code != 3'd7);
   endfunction

   function automatic logic [7:0] status_byte(input logic [AW:0] cnt, input logic ovf, input logic ferr);
      logic [31:0] cnt_w;
      logic [3:0]  cnt_sat;
      cnt_w = 32'(cnt);
      if (cnt_w > 32'd15) begin
         cnt_sat = 4'hF;
      end else begin
         cnt_sat = cnt_w[3:0];
      end
      return {cnt_sat, 2'b00, ovf, ferr};
   endfunction

   // bit 0: metastability stage, bit 1: synchronized, bit 2: previous synchronized sample
   logic [2:0] sck_pipe_r;
   logic [2:0] cs_pipe_r;
   logic [1:0] mosi_pipe_r;

   logic       armed_r;
   logic [2:0] bit_cnt_r;
   logic [7:0] rx_shift_r;
   logic [7:0] rx_byte_r;
   logic       byte_done_r;
   logic       tx_load_r;
   logic       clr_pend_r;
   logic [7:0] tx_shift_r;
   logic       overflow_r;
   logic       frame_err_r;

   logic [2:0]  mem_r [FIFO_DEPTH];
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;

   logic        sck_rise_s, sck_fall_s, cs_n_s, cs_fall_s, cs_rise_s, mosi_s;
   logic        sync_ok_s, push_req_s, sync_err_s, abort_s, clear_req_s;
   logic [AW:0] count_s;
   logic        empty_s, full_s, pop_s, push_s, ovf_set_s;

   assign sck_rise_s  = sck_pipe_r[1] & ~sck_pipe_r[2];
   assign sck_fall_s  = ~sck_pipe_r[1] & sck_pipe_r[2];
   assign cs_n_s      = cs_pipe_r[1];
   assign cs_fall_s   = ~cs_pipe_r[1] & cs_pipe_r[2];
   assign cs_rise_s   = cs_pipe_r[1] & ~cs_pipe_r[2];
   assign mosi_s      = mosi_pipe_r[1];

   assign sync_ok_s   = (rx_byte_r[7:4] == SYNC_NIBBLE);
   assign push_req_s  = byte_done_r & sync_ok_s & code_pushable(rx_byte_r[2:0]);
   assign sync_err_s  = byte_done_r & ~sync_ok_s;
   assign clear_req_s = byte_done_r & (rx_byte_r == CLEAR_BYTE);
   assign abort_s     = cs_rise_s & (bit_cnt_r != 3'd0);

   assign count_s     = wr_ptr_r - rd_ptr_r;
   assign empty_s     = (count_s == '0);
   assign full_s      = (count_s == DEPTH_C);
   assign pop_s       = move_ready & ~empty_s;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign push_s      = push_req_s & (~full_s | pop_s);
   assign ovf_set_s   = push_req_s & full_s & ~pop_s;

   assign move        = mem_r[rd_ptr_r[AW-1:0]];
   assign move_valid  = ~empty_s;
   assign overflow    = overflow_r;
   assign frame_err   = frame_err_r;
   assign miso        = tx_shift_r[7];

   // Two-flop synchronizers; cs resets low so a frame already in progress at release is never seen as a fresh falling edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_pipe_r  <= 3'b000;
         cs_pipe_r   <= 3'b000;
         mosi_pipe_r <= 2'b00;
      end else begin
         sck_pipe_r  <= {sck_pipe_r[1:0], sck};
         cs_pipe_r   <= {cs_pipe_r[1:0], cs_n};
         mosi_pipe_r <= {mosi_pipe_r[0], mosi};
      end
   end

   // Receive shifter: only armed frames (entered via a cs falling edge) are accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed_r     <= 1'b0;
         bit_cnt_r   <= 3'd0;
         rx_shift_r  <= 8'h00;
         rx_byte_r   <= 8'h00;
         byte_done_r <= 1'b0;
      end else begin
         byte_done_r <= 1'b0;
         if (cs_n_s) begin
            armed_r    <= 1'b0;
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 8'h00;
         end else begin
            if (cs_fall_s) begin
               armed_r <= 1'b1;
            end
            if (armed_r && sck_rise_s) begin
               rx_shift_r <= {rx_shift_r[6:0], mosi_s};
               bit_cnt_r  <= bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'd7) begin
                  rx_byte_r   <= {rx_shift_r[6:0], mosi_s};
                  byte_done_r <= 1'b1;
               end
            end
         end
      end
   end

   // Command FIFO storage and pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 3'd0;
         end
      end else begin
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= rx_byte_r[2:0];
            wr_ptr_r                <= wr_ptr_r + 1'b1;
         end
      end
   end

   // Sticky flags; the clear is delayed one cycle so it lands with the status load of the clearing byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_load_r   <= 1'b0;
         clr_pend_r  <= 1'b0;
         overflow_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         tx_load_r  <= byte_done_r;
         clr_pend_r <= clear_req_s;
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else if (clr_pend_r) begin
            overflow_r <= 1'b0;
         end
         if (sync_err_s || abort_s) begin
            frame_err_r <= 1'b1;
         end else if (clr_pend_r) begin
            frame_err_r <= 1'b0;
         end
      end
   end

   // Status transmitter; the falling edge right after a byte's last rising edge keeps the freshly loaded MSB
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_shift_r <= 8'h00;
      end else begin
         if (cs_fall_s) begin
            tx_shift_r <= status_byte(count_s, overflow_r, frame_err_r);
         end else if (cs_n_s || !armed_r) begin
            tx_shift_r <= 8'h00;
         end else if (tx_load_r) begin
            tx_shift_r <= status_byte(count_s, overflow_r, frame_err_r);
         end else if (sck_fall_s && (bit_cnt_r != 3'd0)) begin
            tx_shift_r <= {tx_shift_r[6:0], 1'b0};
         end else begin
            tx_shift_r <= tx_shift_r;
         end
      end
   end

endmodule
